// File: rtl/fixed_point_addsub_acc_pkg.sv
// Shared types and constants for the fixed-point add/sub/accumulate unit.
//   fxp_op_e     : operation select encoding (ADD, SUB, ACC, LOAD)
//   fxp_max()    : most-positive two's-complement bit pattern of a given width
//   fxp_min()    : most-negative two's-complement bit pattern of a given width
package fixed_point_addsub_acc_pkg;

    typedef enum logic [1:0] {
        OpAdd  = 2'd0,
        OpSub  = 2'd1,
        OpAcc  = 2'd2,
        OpLoad = 2'd3
    } fxp_op_e;

    // Constant functions return a wide vector; callers keep the low w bits.
    localparam int unsigned FxpMaxWidth = 64;

    function automatic logic [FxpMaxWidth-1:0] fxp_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [FxpMaxWidth-1:0] fxp_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Combinational reduction of a W+1 bit exact two's-complement sum to W bits.
//   sum      : exact sum, sign-extended by one bit
//   result   : clamped (SATURATE=1) or wrapped (SATURATE=0) W-bit value
//   overflow : exact sum does not fit in W bits
module fixed_point_sat
    import fixed_point_addsub_acc_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [W:0]   sum,
    output logic [W-1:0] result,
    output logic         overflow
);

    localparam logic [FxpMaxWidth-1:0] MaxFull = fxp_max(W);
    localparam logic [FxpMaxWidth-1:0] MinFull = fxp_min(W);
    localparam logic [W-1:0]           MaxVal  = MaxFull[W-1:0];
    localparam logic [W-1:0]           MinVal  = MinFull[W-1:0];

    always_comb begin
        // The guard bit disagrees with the W-bit sign only when the value is out of range.
        overflow = sum[W] ^ sum[W-1];
        result   = sum[W-1:0];
        if (SATURATE && overflow) begin
            result = sum[W] ? MinVal : MaxVal;
        end
    end

endmodule

// File: rtl/fixed_point_addsub_acc.sv
// Two-stage pipelined fixed-point add/subtract/accumulate unit, signed Q(INT_BITS).(FRAC_BITS).
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_op, in_a, in_b sampled on accept
//   in_op               : 0 ADD (a+b), 1 SUB (a-b), 2 ACC (acc+a), 3 LOAD (a)
//   out_valid/out_ready : output handshake; out_result, out_overflow held while stalled
//   sticky_ovf          : set by any overflowing result, cleared by clr_sticky (set wins)
module fixed_point_addsub_acc
    import fixed_point_addsub_acc_pkg::*;
#(
    parameter int unsigned INT_BITS  = 16,
    parameter int unsigned FRAC_BITS = 16,
    parameter bit          SATURATE  = 1'b1,
    localparam int unsigned W        = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_overflow,
    output logic         sticky_ovf,
    input  logic         clr_sticky
);

    fxp_op_e      op;
    logic [W:0]   a_ext, b_ext, acc_ext, exact_sum;
    logic [W-1:0] acc_reduced;
    logic         acc_ovf_unused;
    logic [W-1:0] s2_result;
    logic         s2_ovf;

    logic         s2_adv, s1_adv, in_fire, acc_we;

    logic         s1_valid_q, s1_valid_d;
    logic [W:0]   s1_sum_q, s1_sum_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_result_q, out_result_d;
    logic         out_ovf_q, out_ovf_d;
    logic         sticky_q, sticky_d;
    logic [W-1:0] acc_q, acc_d;

    assign op = fxp_op_e'(in_op);

    // Exact sum at W+1 bits so overflow can be detected from the top two bits.
    always_comb begin
        a_ext   = {in_a[W-1], in_a};
        b_ext   = {in_b[W-1], in_b};
        acc_ext = {acc_q[W-1], acc_q};
        case (op)
            OpAdd:   exact_sum = a_ext + b_ext;
            OpSub:   exact_sum = a_ext - b_ext;
            OpAcc:   exact_sum = acc_ext + a_ext;
            OpLoad:  exact_sum = a_ext;
            default: exact_sum = a_ext;
        endcase
    end

    // The accumulator is updated at accept time so back-to-back ACC beats chain without bubbles.
    fixed_point_sat #(
        .W        (W),
        .SATURATE (SATURATE)
    ) u_acc_sat (
        .sum      (exact_sum),
        .result   (acc_reduced),
        .overflow (acc_ovf_unused)
    );

    fixed_point_sat #(
        .W        (W),
        .SATURATE (SATURATE)
    ) u_s2_sat (
        .sum      (s1_sum_q),
        .result   (s2_result),
        .overflow (s2_ovf)
    );

    // Handshake: in_ready is combinational from out_ready, there is no skid buffer.
    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_fire  = in_valid & in_ready;
    assign acc_we   = in_fire & ((op == OpAcc) | (op == OpLoad));

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_d     = s1_sum_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        sticky_d     = sticky_q;
        acc_d        = acc_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = exact_sum;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d  = 1'b1;
            out_result_d = s2_result;
            out_ovf_d    = s2_ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new overflow on the same edge as a clear keeps the flag set.
        if (s1_adv && s2_ovf) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end

        if (acc_we) begin
            acc_d = acc_reduced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            sticky_q     <= 1'b0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            sticky_q     <= sticky_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_overflow = out_ovf_q;
    assign sticky_ovf   = sticky_q;

endmodule

// File: tb/tb_fixed_point_addsub_acc.sv
// Bench: a saturating and a wrapping instance share all inputs; results are checked
// against an integer-arithmetic reference model through an in-order expectation queue.
module tb_fixed_point_addsub_acc;

    localparam int unsigned IB = 4;
    localparam int unsigned FB = 4;
    localparam int unsigned W  = IB + FB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic         out_ready;
    logic         clr_sticky;

    logic         in_ready_s, out_valid_s, out_ovf_s, sticky_s;
    logic [W-1:0] out_result_s;
    logic         in_ready_w, out_valid_w, out_ovf_w, sticky_w;
    logic [W-1:0] out_result_w;

    always #5 clk = ~clk;

    fixed_point_addsub_acc #(.INT_BITS(IB), .FRAC_BITS(FB), .SATURATE(1'b1)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .out_result   (out_result_s),
        .out_overflow (out_ovf_s),
        .sticky_ovf   (sticky_s),
        .clr_sticky   (clr_sticky)
    );

    fixed_point_addsub_acc #(.INT_BITS(IB), .FRAC_BITS(FB), .SATURATE(1'b0)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid_w),
        .out_ready    (out_ready),
        .out_result   (out_result_w),
        .out_overflow (out_ovf_w),
        .sticky_ovf   (sticky_w),
        .clr_sticky   (clr_sticky)
    );

    typedef struct packed {
        logic [7:0] rs;
        logic       os;
        logic [7:0] rw;
        logic       ow;
    } exp_t;

    exp_t q[$];
    int   acc_s, acc_w;
    bit   stk_s, stk_w;
    int   tests = 0;
    int   fails = 0;
    bit   last_acc;
    int   n_acc;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int exact(input logic [1:0] op, input int a, input int b, input int acc);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return acc + a;
            default: return a;
        endcase
    endfunction

    // Reference: plain integer arithmetic, clamp or modulo-256 to the Q4.4 range.
    task automatic model_accept(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   es, ew, cs;
        logic [31:0] ewv;
        es = exact(op, sx(a), sx(b), acc_s);
        ew = exact(op, sx(a), sx(b), acc_w);
        e.os = (es > 127) || (es < -128);
        cs = (es > 127) ? 127 : ((es < -128) ? -128 : es);
        e.rs = 8'(cs);
        e.ow = (ew > 127) || (ew < -128);
        ewv = ew;
        e.rw = ewv[7:0];
        if (op == 2'd2 || op == 2'd3) begin
            acc_s = cs;
            acc_w = sx(e.rw);
        end
        if (e.os) stk_s = 1'b1;
        if (e.ow) stk_w = 1'b1;
        q.push_back(e);
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        exp_t e;
        bit   fire_in, fire_out;
        #1;
        fire_in  = in_valid && in_ready_s;
        fire_out = out_valid_s && out_ready;
        if (fire_out) begin
            chk1("q_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk8("res_sat", out_result_s, e.rs);
                chk1("ovf_sat", out_ovf_s, e.os);
                chk1("vld_wrap", out_valid_w, 1'b1);
                chk8("res_wrap", out_result_w, e.rw);
                chk1("ovf_wrap", out_ovf_w, e.ow);
            end
        end
        if (fire_in) model_accept(in_op, in_a, in_b);
        last_acc = fire_in;
        if (fire_in) n_acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tick();
        chk1({"accept_", tag}, last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid_s); i++) tick();
        chk1("drain_done", (q.size() == 0) && !out_valid_s, 1'b1);
    endtask

    task automatic clear_sticky();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        stk_s = 1'b0;
        stk_w = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa[4];
        logic [7:0] sb[4];
        int nb;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        acc_s = 0; acc_w = 0; stk_s = 1'b0; stk_w = 1'b0; n_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid_s, 1'b0);
        chk8("rst_out_result", out_result_s, 8'h00);
        chk1("rst_out_ovf", out_ovf_s, 1'b0);
        chk1("rst_sticky", sticky_s, 1'b0);
        chk1("rst_in_ready", in_ready_s, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: 1.5 + 2.25 = 3.75, visible exactly two edges after accept.
        out_ready = 1'b1;
        send("add", 2'd0, 8'h18, 8'h24);
        chk1("lat_e1_valid", out_valid_s, 1'b0);
        tick();
        chk1("lat_e2_valid", out_valid_s, 1'b1);
        chk8("lat_e2_result", out_result_s, 8'h3C);
        drain();

        // Positive and negative overflow; clamp vs wrap.
        send("add_ovf", 2'd0, 8'h7F, 8'h01);
        send("sub_ovf", 2'd1, 8'h80, 8'h01);
        drain();
        chk1("sticky_sat", sticky_s, 1'b1);
        chk1("sticky_wrap", sticky_w, 1'b1);
        clear_sticky();
        chk1("sticky_clr_sat", sticky_s, 1'b0);
        chk1("sticky_clr_wrap", sticky_w, 1'b0);

        // LOAD then back-to-back ACC: results on consecutive cycles.
        send("load", 2'd3, 8'h10, 8'h00);
        send("acc1", 2'd2, 8'h10, 8'h00);
        chk1("chain_v1", out_valid_s, 1'b1);
        send("acc2", 2'd2, 8'h10, 8'h00);
        chk1("chain_v2", out_valid_s, 1'b1);
        send("acc3", 2'd2, 8'h10, 8'h00);
        chk1("chain_v3", out_valid_s, 1'b1);
        tick();
        chk1("chain_v4", out_valid_s, 1'b1);
        chk8("chain_last", out_result_s, 8'h40);
        drain();
        send("acc_sat", 2'd2, 8'h70, 8'h00);
        drain();
        clear_sticky();

        // Set and clear on the same edge: set wins; clear alone afterwards works.
        send("ovf_beat", 2'd0, 8'h7F, 8'h7F);
        clr_sticky = 1'b1;
        tick();
        chk1("same_edge_valid", out_valid_s, 1'b1);
        chk1("same_edge_sticky", sticky_s, 1'b1);
        chk1("same_edge_sticky_w", sticky_w, 1'b1);
        tick();
        clr_sticky = 1'b0;
        stk_s = 1'b0;
        stk_w = 1'b0;
        chk1("clr_alone_sticky", sticky_s, 1'b0);
        drain();

        // Backpressure: four beats offered while the sink stalls for five cycles.
        for (int i = 0; i < 4; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
        nb = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_op = 2'd0; in_a = sa[nb]; in_b = sb[nb];
            tick();
            if (last_acc) nb++;
            if (out_valid_s && q.size() != 0) chk8("stall_hold", out_result_s, q[0].rs);
        end
        chk1("stall_two_accepts", nb == 2, 1'b1);
        chk1("stall_in_ready", in_ready_s, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && nb < 4; c++) begin
            in_valid = 1'b1; in_op = 2'd0; in_a = sa[nb]; in_b = sb[nb];
            tick();
            if (last_acc) nb++;
        end
        chk1("stall_all_sent", nb == 4, 1'b1);
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk1("rand_sticky_sat", sticky_s, stk_s);
        chk1("rand_sticky_wrap", sticky_w, stk_w);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send("pre_rst0", 2'd2, 8'h11, 8'h00);
        send("pre_rst1", 2'd2, 8'h22, 8'h00);
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", out_valid_s, 1'b0);
        chk8("async_rst_result", out_result_s, 8'h00);
        chk8("async_rst_result_w", out_result_w, 8'h00);
        q.delete();
        acc_s = 0; acc_w = 0; stk_s = 1'b0; stk_w = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        tick();
        chk1("post_rst_quiet", out_valid_s, 1'b0);
        send("acc_after_rst", 2'd2, 8'h05, 8'h00);
        tick();
        chk8("acc_after_rst_res", out_result_s, 8'h05);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fixed_point_addsub_acc.md
Name: fixed_point_addsub_acc

Overview:
- Parametrised, 2-stage pipelined fixed-point add/subtract/accumulate unit in signed two's-complement Q(INT_BITS).(FRAC_BITS) format.
- Supports selectable saturation or wrap, per-result overflow and a sticky overflow flag.
- Uses valid/ready handshakes on both sides, so it can sit between the vertex/raster datapath stages and stall cleanly under backpressure.

Parameters:
- INT_BITS, 16, integer bits including the sign bit.
- FRAC_BITS, 16, fraction bits. W = INT_BITS+FRAC_BITS.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_op  in  2  operation select: 0 ADD, 1 SUB, 2 ACC, 3 LOAD.
- in_a  in  W  operand A.
- in_b  in  W  operand B; ignored for ACC and LOAD.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_result  out  W  result.
- out_overflow  out  1  overflow flag for this result.
- sticky_ovf  out  1  set by any overflowing result, held until cleared.
- clr_sticky  in  1  synchronous clear of sticky_ovf.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_result=0, out_overflow=0, sticky_ovf=0, acc=0. Reset mid-operation discards all in-flight beats; nothing is emitted after release.
- Exact sum is computed at W+1 bits by sign-extending both operands:
  - ADD = a+b; SUB = a-b; ACC = acc+a; LOAD = a (never overflows).
- Overflow = bit W != bit W-1 of the exact sum.
- Reduction to W bits:
  - SATURATE=1: positive overflow -> 0x7..F; negative overflow -> 0x8..0.
  - SATURATE=0: low W bits.
  - out_overflow is asserted either way.
- Accumulator:
  - acc updates at the accept edge of ACC/LOAD with the reduced (saturated/wrapped) value.
  - Back-to-back ACC beats therefore see each other with no bubble.
  - ADD/SUB never touch acc.
- Stage 1 registers the W+1 exact sum plus a valid bit on accept. Stage 2 reduces it and registers out_result/out_overflow.
- Latency: 2 cycles from the accept edge to out_valid when unstalled. Throughput: 1 beat/cycle.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv, combinational from out_ready; no skid buffer.
- Under stall, out_result/out_overflow/out_valid hold stable until consumed. Beats are never dropped, duplicated or reordered.
- out_valid deasserts after a transfer unless stage 1 advances in the same cycle.
- sticky_ovf:
  - Set on the edge where a beat with overflow=1 loads the output register.
  - clr_sticky clears it. If set and clear fall on the same edge, set wins.
- in_op and operands are sampled only on accept; values while in_ready=0 are don't-care.

Decomposition:
- fixed_point package gains:
  - fxp_op_e enum (ADD/SUB/ACC/LOAD).
  - Width-parametrised max/min constant functions.
- Sub-module fixed_point_sat: combinational W+1 -> W reduction with SATURATE parameter and overflow output. Instantiated twice: accumulator update path and stage 2.

Test Plan (INT_BITS=4, FRAC_BITS=4, W=8):
- ADD 0x18 (1.5) + 0x24 (2.25) -> 0x3C, overflow=0, out_valid exactly 2 cycles after accept.
- SATURATE=1: ADD 0x7F+0x01 -> 0x7F ovf=1; SUB 0x80-0x01 -> 0x80 ovf=1; sticky_ovf=1. Same with SATURATE=0 -> 0x80 and 0x7F.
- LOAD 0x10 then ACC 0x10 ×3 back-to-back -> results 0x10, 0x20, 0x30, 0x40 on consecutive cycles; then ACC 0x70 -> 0x7F ovf=1 (SAT).
- Hold out_ready=0 for 5 cycles while presenting 4 beats:
  - in_ready drops after 2 accepts; out_result stable.
  - On release, all beats emerge in order, none lost or duplicated.
- clr_sticky asserted on the same edge an overflowing result loads -> sticky_ovf stays 1. Next cycle clr_sticky alone -> 0.
- Assert rst_n=0 asynchronously with 2 beats in flight -> out_valid=0, out_result=0 immediately. After release, a lone ACC 0x05 -> 0x05 (acc was reset).
